instr_sequencer: RTL and testbench
==================================

INSTR_SEQUENCER -- requirements
Module: instr_sequencer

Interface
REQ-001 SHALL have parameter RESET_PC, default 16'h0000, meaning the program counter value loaded at reset.
REQ-002 SHALL have parameter MEM_WAIT, default 1, meaning the number of wait cycles (1..7) between RAM Enable and valid Ram_Out.
REQ-003 SHALL have port Clk  input  1  system clock; all state changes occur on the rising edge.
REQ-004 SHALL have port Rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port Start  input  1  one-cycle pulse that leaves IDLE or HALT and begins fetching at the current Pc.
REQ-006 SHALL have port Ram_Out  input  32  RAM read data.
REQ-007 SHALL have port Result  input  32  ALU result.
REQ-008 SHALL have port New_Flag  input  4  ALU flags {N,Z,C,V}.
REQ-009 SHALL have port Store_Data  input  32  register-bank read of Instr[22:19], used by STR.
REQ-010 SHALL have ports Ram_Enable, Ram_RW  output  1 each  RAM strobe and direction (RW=1 read, RW=0 write).
REQ-011 SHALL have ports Ram_Address  output  16 and Ram_In  output  32  RAM address and write data.
REQ-012 SHALL have port Instr  output  32  latched instruction register driving the decode fields.
REQ-013 SHALL have ports Reg_Write  output  1 and Wb_Sel  output  1  register write strobe and source select (0 = Result, 1 = Ram_Out).
REQ-014 SHALL have ports Flag  output  4, Pc  output  16, Busy  output  1, Halted  output  1.

Function
REQ-015 SHALL implement the states IDLE, FETCH, FETCH_WAIT, DECODE, EXEC, MEM, MEM_WAIT, WB and HALT.
REQ-016 IDLE SHALL go to FETCH on Start=1 and otherwise hold.
REQ-017 FETCH SHALL drive Ram_Enable=1, Ram_RW=1 and Ram_Address=Pc for one cycle, then go to FETCH_WAIT.
REQ-018 FETCH_WAIT SHALL last MEM_WAIT cycles, then latch Ram_Out into Instr, increment Pc by 1 (wrapping 16'hFFFF to 16'h0000) and go to DECODE.
REQ-019 DECODE SHALL evaluate the condition Instr[31:28] against Flag, where Flag[3]=N, Flag[2]=Z, Flag[1]=C and Flag[0]=V.
REQ-020 The condition codes SHALL be: 0 EQ (Z), 1 NE, 2 CS (C), 3 CC, 4 MI (N), 5 PL, 6 VS (V), 7 VC, E AL; codes 8-D and F SHALL evaluate false.
REQ-021 A false condition SHALL skip the instruction by returning from DECODE directly to FETCH, with no register write, no RAM access and no flag change.
REQ-022 Instr[27:24] SHALL be decoded as: 4'hC LDR, 4'hD STR, 4'hE B, 4'hF HLT, and every other value an ALU operation.
REQ-023 An ALU operation SHALL go DECODE -> EXEC -> WB.
REQ-024 In WB for an ALU operation, the block SHALL pulse Reg_Write=1 with Wb_Sel=0, and load Flag from New_Flag when Instr[23]=1.
REQ-025 LDR SHALL go to MEM, drive a read at Ram_Address=Instr[18:3], pass through MEM_WAIT, then WB with Reg_Write=1 and Wb_Sel=1.
REQ-026 STR SHALL go to MEM, drive Ram_RW=0, Ram_Address=Instr[18:3] and Ram_In=Store_Data for one cycle, then return to FETCH with no register write.
REQ-027 B SHALL load Pc with Instr[18:3] in EXEC and then return to FETCH.
REQ-028 HLT SHALL enter HALT and assert Halted=1; a Start pulse in HALT SHALL resume at FETCH.
REQ-029 Instruction latency with MEM_WAIT=1 SHALL be: ALU 5 cycles, LDR 7, STR 5, B 4, skipped instruction 3.
REQ-030 Start SHALL be ignored in every state except IDLE and HALT.
REQ-031 Ram_Enable SHALL be 0 in every state except FETCH and MEM.
REQ-032 Reg_Write SHALL be high only in WB.
REQ-033 Busy SHALL be 1 in every state except IDLE and HALT.
REQ-034 An out-of-range MEM_WAIT value SHALL be clamped to the range 1..7.

Reset
REQ-035 Rst_n=0 SHALL immediately force state IDLE, Pc=RESET_PC, Instr=0, Flag=0, and drive Ram_Enable, Reg_Write, Wb_Sel, Busy and Halted to 0, Ram_RW=1, Ram_Address=0 and Ram_In=0.
REQ-036 Reset asserted mid-instruction SHALL abort the instruction with no register write and with Ram_Enable deasserted asynchronously.

Configuration
REQ-037 Macro COND_EXEC_EN SHALL compile conditional execution in or out.
REQ-038 With COND_EXEC_EN defined, conditions SHALL be evaluated per REQ-019 to REQ-021.
REQ-039 Without COND_EXEC_EN, every instruction SHALL execute as AL, and Flag SHALL still update on S=1.

Verification
REQ-040 Reset then Start with RAM[0]=ALU op (S=1, Cond=E), Result=5 and New_Flag=4'b0000 -> Reg_Write pulses in cycle 5 with Wb_Sel=0, Flag=0 and Pc=1.
REQ-041 LDR with Instr[18:3]=16'h0010 and RAM[0x10]=32'hCCCCFFFF -> read at 0x0010, then WB with Wb_Sel=1, 7 cycles total.
REQ-042 STR with Instr[18:3]=16'h0004 and Store_Data=32'hFFFF00DD -> a single cycle with Ram_Enable=1, RW=0, Address=0x0004 and In=32'hFFFF00DD.
REQ-043 With Flag Z=0 and an instruction using Cond=0 (EQ) -> no Reg_Write, Pc advances by 1, 3 cycles; without COND_EXEC_EN -> the instruction executes.
REQ-044 B to 16'hFFFF followed by a fetch -> Pc wraps to 0; HLT -> Halted=1 and Busy=0; Start -> resumes fetching.
REQ-045 Rst_n low during MEM_WAIT of an LDR -> Ram_Enable=0 and Reg_Write never asserted, with state IDLE and Pc=RESET_PC.

Source files
------------

// File: rtl/instr_sequencer.sv
// Instruction fetch/decode/execute sequencer driving RAM, register-bank writeback and flags.
// Define COND_EXEC_EN to enable condition-code evaluation; otherwise every instruction runs as AL.
module instr_sequencer #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter int          MEM_WAIT = 1
) (
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic        Start,
  input  logic [31:0] Ram_Out,
  input  logic [31:0] Result,
  input  logic [3:0]  New_Flag,
  input  logic [31:0] Store_Data,
  output logic        Ram_Enable,
  output logic        Ram_RW,
  output logic [15:0] Ram_Address,
  output logic [31:0] Ram_In,
  output logic [31:0] Instr,
  output logic        Reg_Write,
  output logic        Wb_Sel,
  output logic [3:0]  Flag,
  output logic [15:0] Pc,
  output logic        Busy,
  output logic        Halted
);

  localparam int       MW_C    = (MEM_WAIT < 1) ? 1 : ((MEM_WAIT > 7) ? 7 : MEM_WAIT);
  localparam logic [2:0] MW_INIT = 3'(MW_C - 1);

  localparam logic [3:0] OP_LDR = 4'hC;
  localparam logic [3:0] OP_STR = 4'hD;
  localparam logic [3:0] OP_B   = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_FETCH_WAIT, S_DECODE, S_EXEC,
    S_MEM, S_MEM_WAIT, S_WB, S_HALT
  } state_t;

  state_t      r_state;
  logic [15:0] r_pc;
  logic [31:0] r_instr;
  logic [3:0]  r_flag;
  logic [2:0]  r_wait;
  logic        r_ram_en;
  logic        r_ram_rw;
  logic [15:0] r_ram_addr;
  logic [31:0] r_ram_in;
  logic        r_reg_write;
  logic        r_wb_sel;
  logic        r_busy;
  logic        r_halted;

  logic [3:0]  w_op;
  logic [15:0] w_target;
  logic        w_cond_pass;
  logic        w_unused;

  assign w_op     = r_instr[27:24];
  assign w_target = r_instr[18:3];
  // ALU result is steered by the external writeback mux, not by the sequencer.
  assign w_unused = ^Result;

`ifdef COND_EXEC_EN
  always_comb begin
    w_cond_pass = 1'b0;
    case (r_instr[31:28])
      4'h0:    w_cond_pass =  r_flag[2];
      4'h1:    w_cond_pass = !r_flag[2];
      4'h2:    w_cond_pass =  r_flag[1];
      4'h3:    w_cond_pass = !r_flag[1];
      4'h4:    w_cond_pass =  r_flag[3];
      4'h5:    w_cond_pass = !r_flag[3];
      4'h6:    w_cond_pass =  r_flag[0];
      4'h7:    w_cond_pass = !r_flag[0];
      4'hE:    w_cond_pass = 1'b1;
      default: w_cond_pass = 1'b0;
    endcase
  end
`else
  assign w_cond_pass = 1'b1;
`endif

  // Outputs are registered: each transition presets the strobes of the state being entered.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_state     <= S_IDLE;
      r_pc        <= RESET_PC;
      r_instr     <= '0;
      r_flag      <= '0;
      r_wait      <= '0;
      r_ram_en    <= 1'b0;
      r_ram_rw    <= 1'b1;
      r_ram_addr  <= '0;
      r_ram_in    <= '0;
      r_reg_write <= 1'b0;
      r_wb_sel    <= 1'b0;
      r_busy      <= 1'b0;
      r_halted    <= 1'b0;
    end else begin
      r_ram_en    <= 1'b0;
      r_ram_rw    <= 1'b1;
      r_ram_addr  <= '0;
      r_ram_in    <= '0;
      r_reg_write <= 1'b0;
      r_wb_sel    <= 1'b0;
      case (r_state)
        S_IDLE, S_HALT: begin
          if (Start) begin
            r_state    <= S_FETCH;
            r_ram_en   <= 1'b1;
            r_ram_addr <= r_pc;
            r_busy     <= 1'b1;
            r_halted   <= 1'b0;
          end
        end
        S_FETCH: begin
          r_state <= S_FETCH_WAIT;
          r_wait  <= MW_INIT;
        end
        S_FETCH_WAIT: begin
          if (r_wait == 3'd0) begin
            r_instr <= Ram_Out;
            r_pc    <= r_pc + 16'd1;
            r_state <= S_DECODE;
          end else begin
            r_wait <= r_wait - 3'd1;
          end
        end
        S_DECODE: begin
          if (!w_cond_pass) begin
            r_state    <= S_FETCH;
            r_ram_en   <= 1'b1;
            r_ram_addr <= r_pc;
          end else if (w_op == OP_HLT) begin
            r_state  <= S_HALT;
            r_busy   <= 1'b0;
            r_halted <= 1'b1;
          end else begin
            r_state <= S_EXEC;
          end
        end
        S_EXEC: begin
          case (w_op)
            OP_LDR: begin
              r_state    <= S_MEM;
              r_ram_en   <= 1'b1;
              r_ram_addr <= w_target;
            end
            OP_STR: begin
              r_state    <= S_MEM;
              r_ram_en   <= 1'b1;
              r_ram_rw   <= 1'b0;
              r_ram_addr <= w_target;
              r_ram_in   <= Store_Data;
            end
            OP_B: begin
              r_pc       <= w_target;
              r_state    <= S_FETCH;
              r_ram_en   <= 1'b1;
              r_ram_addr <= w_target;
            end
            default: begin
              r_state     <= S_WB;
              r_reg_write <= 1'b1;
            end
          endcase
        end
        S_MEM: begin
          if (w_op == OP_LDR) begin
            r_state <= S_MEM_WAIT;
            r_wait  <= MW_INIT;
          end else begin
            r_state    <= S_FETCH;
            r_ram_en   <= 1'b1;
            r_ram_addr <= r_pc;
          end
        end
        S_MEM_WAIT: begin
          if (r_wait == 3'd0) begin
            r_state     <= S_WB;
            r_reg_write <= 1'b1;
            r_wb_sel    <= 1'b1;
          end else begin
            r_wait <= r_wait - 3'd1;
          end
        end
        S_WB: begin
          if (w_op != OP_LDR && r_instr[23])
            r_flag <= New_Flag;
          r_state    <= S_FETCH;
          r_ram_en   <= 1'b1;
          r_ram_addr <= r_pc;
        end
        default: begin
          r_state  <= S_IDLE;
          r_busy   <= 1'b0;
          r_halted <= 1'b0;
        end
      endcase
    end
  end

  assign Ram_Enable  = r_ram_en;
  assign Ram_RW      = r_ram_rw;
  assign Ram_Address = r_ram_addr;
  assign Ram_In      = r_ram_in;
  assign Instr       = r_instr;
  assign Reg_Write   = r_reg_write;
  assign Wb_Sel      = r_wb_sel;
  assign Flag        = r_flag;
  assign Pc          = r_pc;
  assign Busy        = r_busy;
  assign Halted      = r_halted;

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed self-checking bench for instr_sequencer with a one-wait-cycle RAM model.
module tb_instr_sequencer;

  logic        Clk;
  logic        Rst_n;
  logic        Start;
  logic [31:0] Ram_Out;
  logic [31:0] Result;
  logic [3:0]  New_Flag;
  logic [31:0] Store_Data;
  logic        Ram_Enable;
  logic        Ram_RW;
  logic [15:0] Ram_Address;
  logic [31:0] Ram_In;
  logic [31:0] Instr;
  logic        Reg_Write;
  logic        Wb_Sel;
  logic [3:0]  Flag;
  logic [15:0] Pc;
  logic        Busy;
  logic        Halted;

  instr_sequencer #(.RESET_PC(16'h0000), .MEM_WAIT(1)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .Start(Start), .Ram_Out(Ram_Out), .Result(Result),
    .New_Flag(New_Flag), .Store_Data(Store_Data), .Ram_Enable(Ram_Enable),
    .Ram_RW(Ram_RW), .Ram_Address(Ram_Address), .Ram_In(Ram_In), .Instr(Instr),
    .Reg_Write(Reg_Write), .Wb_Sel(Wb_Sel), .Flag(Flag), .Pc(Pc), .Busy(Busy),
    .Halted(Halted)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  logic [31:0] mem [0:65535];
  logic [15:0] rd_addr;
  int          cyc;

  initial rd_addr = '0;
  initial cyc = 0;
  always @(posedge Clk) begin
    cyc <= cyc + 1;
    if (Ram_Enable && Ram_RW) rd_addr <= Ram_Address;
  end
  assign Ram_Out = mem[rd_addr];

  int          rw_count = 0;
  int          last_rw_cyc = -1;
  logic        last_rw_sel = 1'b0;
  logic [31:0] last_rw_data = '0;
  int          wr_count = 0;
  logic [15:0] wr_addr = '0;
  logic [31:0] wr_data = '0;
  int          ld_rd_cyc = -1;

  always @(negedge Clk) begin
    if (Reg_Write) begin
      rw_count++;
      last_rw_cyc  = cyc;
      last_rw_sel  = Wb_Sel;
      last_rw_data = Wb_Sel ? Ram_Out : Result;
    end
    if (Ram_Enable && !Ram_RW) begin
      wr_count++;
      wr_addr = Ram_Address;
      wr_data = Ram_In;
    end
    if (Ram_Enable && Ram_RW && Ram_Address == 16'h0010) ld_rd_cyc = cyc;
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_fetch(input logic [15:0] addr, output int at_cyc);
    logic found;
    found  = 1'b0;
    at_cyc = -1;
    for (int i = 0; i < 60 && !found; i++) begin
      @(negedge Clk);
      if (Ram_Enable && Ram_RW && Ram_Address == addr) begin
        found  = 1'b1;
        at_cyc = cyc;
      end
    end
    #1;
    if (!found) check("fetch_timeout", {48'd0, addr}, 64'hFFFF_FFFF);
  endtask

  task automatic pulse_start(output int s);
    @(negedge Clk);
    Start = 1'b1;
    s = cyc;
    @(posedge Clk);
    #1 Start = 1'b0;
  endtask

  int s0, f0, f1, f2, f3, f4, f5, rw_before;
  logic seen;

  initial begin
    for (int unsigned a = 0; a < 65536; a++) mem[a] = 32'hEF00_0000;
    mem[16'h0000] = 32'hE080_0000;
    mem[16'h0001] = 32'hEC00_0080;
    mem[16'h0002] = 32'hED00_0020;
    mem[16'h0003] = 32'h0100_0000;
    mem[16'h0004] = 32'hEE07_FFF8;
    mem[16'h0010] = 32'hCCCC_FFFF;

    Rst_n = 1'b0; Start = 1'b0; Result = 32'd5; New_Flag = 4'b0000;
    Store_Data = 32'hFFFF_00DD;
    repeat (3) @(negedge Clk);
    check("rst_pc", Pc, 16'h0000);
    check("rst_instr", Instr, 32'h0);
    check("rst_flag", Flag, 4'h0);
    check("rst_ctl", {Ram_Enable, Ram_RW, Reg_Write, Wb_Sel, Busy, Halted}, 6'b010000);
    check("rst_addr_in", {Ram_Address, Ram_In}, 48'h0);
    Rst_n = 1'b1;

    pulse_start(s0);
    wait_fetch(16'h0000, f0);
    check("start_fetch_cyc", f0 - s0, 1);
    wait_fetch(16'h0001, f1);
    check("alu_latency", f1 - f0, 5);
    check("alu_rw_cycle", last_rw_cyc - s0, 5);
    check("alu_rw", {rw_count, 31'd0, last_rw_sel}, {32'd1, 32'd0});
    check("alu_flag_pc", {Flag, Pc}, {4'h0, 16'h0001});

    wait_fetch(16'h0002, f2);
    check("ldr_latency", f2 - f1, 7);
    check("ldr_read_cyc", ld_rd_cyc - f1, 4);
    check("ldr_wb", {rw_count, 31'd0, last_rw_sel}, {32'd2, 32'd1});
    check("ldr_data", last_rw_data, 32'hCCCC_FFFF);

    wait_fetch(16'h0003, f3);
    check("str_latency", f3 - f2, 5);
    check("str_write", {wr_count, wr_addr, wr_data}, {32'd1, 16'h0004, 32'hFFFF_00DD});
    check("str_no_rw", rw_count, 2);

    wait_fetch(16'h0004, f4);
`ifdef COND_EXEC_EN
    check("eq_skip_latency", f4 - f3, 3);
    check("eq_skip_rw", rw_count, 2);
`else
    check("eq_exec_latency", f4 - f3, 5);
    check("eq_exec_rw", rw_count, 3);
`endif
    check("eq_pc", Pc, 16'h0004);

    wait_fetch(16'hFFFF, f5);
    check("b_latency", f5 - f4, 4);

    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge Clk);
      if (Halted) seen = 1'b1;
    end
    check("hlt_seen", seen, 1'b1);
    check("hlt_state", {Pc, Halted, Busy}, {16'h0000, 1'b1, 1'b0});
    repeat (4) @(negedge Clk);
    check("hlt_hold", {Halted, Ram_Enable}, 2'b10);

    New_Flag = 4'b0100;
    pulse_start(s0);
    wait_fetch(16'h0000, f0);
    check("resume_fetch_cyc", f0 - s0, 1);
    check("resume_busy", {Busy, Halted}, 2'b10);
    wait_fetch(16'h0001, f1);
    check("resume_flag", Flag, 4'b0100);

    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge Clk);
      if (Ram_Enable && Ram_RW && Ram_Address == 16'h0010) seen = 1'b1;
    end
    check("ldr2_read_seen", seen, 1'b1);
    @(negedge Clk);
    rw_before = rw_count;
    #2 Rst_n = 1'b0;
    #1;
    check("midrst_ctl", {Ram_Enable, Reg_Write, Busy, Halted}, 4'b0000);
    check("midrst_state", {Pc, Flag, Instr}, {16'h0000, 4'h0, 32'h0});
    repeat (3) @(negedge Clk);
    check("midrst_no_rw", rw_count, rw_before);
    Rst_n = 1'b1;
    repeat (3) @(negedge Clk);
    check("post_rst_idle", {Busy, Ram_Enable, Pc}, {1'b0, 1'b0, 16'h0000});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
